// File: rtl/spi_pkg.sv
// Shared SPI definitions: transfer width, bus mode and master FSM states.
package spi_pkg;

  localparam int unsigned SPI_DATA_W = 8;

  // Mode 0: CPOL=0 (sclk idles low), CPHA=0 (sample on rising edge).
  localparam logic [1:0] SPI_MODE = 2'd0;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    XFER,
    HOLD
  } spi_state_t;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator for the SPI master; restarts from zero on clear.
module spi_clk_div #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  logic [7:0] cnt;

  assign tick = (cnt == 8'(CLK_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI master, LSB first: SETUP, 16 sclk half-periods, HOLD, then done.
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned DATA_W  = SPI_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              sclk,
  output logic              cs_n,
  output logic              mosi,
  input  logic              miso
);

  localparam int unsigned EDGE_W    = $clog2(2 * DATA_W);
  localparam logic        SCLK_IDLE = SPI_MODE[1];

  spi_state_t        state, state_next;
  logic [EDGE_W-1:0] edge_cnt, edge_cnt_next;
  logic [DATA_W-1:0] tx_shift, tx_shift_next;
  logic [DATA_W-1:0] rx_shift, rx_shift_next;
  logic [DATA_W-1:0] rx_data_next;
  logic              sclk_next, cs_n_next, mosi_next, done_next;
  logic              tick, div_clear;

  // Divider restarts on every state change and stays parked while idle.
  assign div_clear = (state_next != state) || (state == IDLE);
  assign busy      = (state != IDLE);

  spi_clk_div #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_div (
    .clk  (clk),
    .reset(reset),
    .clear(div_clear),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      edge_cnt <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      sclk     <= SCLK_IDLE;
      cs_n     <= 1'b1;
      mosi     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_next;
      edge_cnt <= edge_cnt_next;
      tx_shift <= tx_shift_next;
      rx_shift <= rx_shift_next;
      rx_data  <= rx_data_next;
      sclk     <= sclk_next;
      cs_n     <= cs_n_next;
      mosi     <= mosi_next;
      done     <= done_next;
    end
  end

  always_comb begin
    state_next    = state;
    edge_cnt_next = edge_cnt;
    tx_shift_next = tx_shift;
    rx_shift_next = rx_shift;
    rx_data_next  = rx_data;
    sclk_next     = sclk;
    cs_n_next     = cs_n;
    mosi_next     = mosi;
    done_next     = 1'b0;

    unique case (state)
      IDLE: begin
        sclk_next = SCLK_IDLE;
        cs_n_next = 1'b1;
        if (start) begin
          tx_shift_next = tx_data;
          rx_shift_next = '0;
          edge_cnt_next = '0;
          mosi_next     = tx_data[0];
          cs_n_next     = 1'b0;
          state_next    = SETUP;
        end
      end

      SETUP: begin
        if (tick) begin
          state_next = XFER;
        end
      end

      XFER: begin
        if (tick) begin
          sclk_next = ~sclk;
          if (!sclk) begin
            rx_shift_next = {miso, rx_shift[DATA_W-1:1]};
          end else begin
            // Next bit goes out on the falling edge; bit 0 was set on start.
            tx_shift_next = tx_shift >> 1;
            mosi_next     = tx_shift[1];
          end
          if (edge_cnt == EDGE_W'(2 * DATA_W - 1)) begin
            edge_cnt_next = '0;
            state_next    = HOLD;
          end else begin
            edge_cnt_next = edge_cnt + EDGE_W'(1);
          end
        end
      end

      HOLD: begin
        if (tick) begin
          cs_n_next    = 1'b1;
          done_next    = 1'b1;
          rx_data_next = rx_shift;
          state_next   = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

endmodule
